lcplc_input_sequencer: RTL
==========================

Name: lcplc_input_sequencer

Overview:
- Sits between a raw sample stream and the LCPLC coder input.
- Configured once per image with slice geometry, band count and slice count.
- Forwards samples in slice-major / band / raster-within-slice order and generates the x_last_r/s/b/i flags.
- Latches cfg_quant_shift and cfg_threshold at start and holds them stable for the coder for the whole image.

Parameters:
- DATA_WIDTH, 16, sample width.
- MAX_SLICE_SIZE_LOG, 8, log2 of max samples per slice per band.
- BAND_WIDTH, 10, width of band count field.
- SLICE_CNT_WIDTH, 16, width of slice count field.
- QUANTIZER_SHIFT_WIDTH, 4, width of quantizer shift.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  pulse; latches cfg_*, begins an image (ignored unless IDLE).
- cfg_cols_m1  in  MAX_SLICE_SIZE_LOG  slice width minus 1.
- cfg_rows_m1  in  MAX_SLICE_SIZE_LOG  slice height minus 1.
- cfg_bands_m1  in  BAND_WIDTH  bands minus 1.
- cfg_slices_m1  in  SLICE_CNT_WIDTH  slices minus 1.
- cfg_quant_shift_in  in  QUANTIZER_SHIFT_WIDTH  quantizer shift for this image.
- cfg_threshold_in  in  64  threshold for this image.
- s_valid  in  1  raw sample valid.
- s_ready  out  1  raw sample ready.
- s_data  in  DATA_WIDTH  raw sample.
- x_valid  out  1  to coder.
- x_ready  in  1  from coder.
- x_data  out  DATA_WIDTH  sample to coder.
- x_last_r  out  1  last sample of a slice row.
- x_last_s  out  1  last sample of the slice in the current band.
- x_last_b  out  1  last sample of the last band of the slice.
- x_last_i  out  1  last sample of the image.
- cfg_quant_shift  out  QUANTIZER_SHIFT_WIDTH  latched, to coder.
- cfg_threshold  out  64  latched, to coder.
- busy  out  1  high from accepted start until last output handshake.
- cfg_error  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset (async, any state):
  - State IDLE; all counters cleared; output register empty.
  - x_valid, s_ready, busy, cfg_error and all x_last_* 0; x_data 0.
  - cfg_quant_shift 0, cfg_threshold 0.
- States:
  - IDLE: start with a valid config → latch all cfg_*, clear counters, go to RUN. Latched cfg_* outputs change only on this transition.
  - Config is invalid if (cfg_cols_m1+1)*(cfg_rows_m1+1) > 2^MAX_SLICE_SIZE_LOG. Product is computed at 2*MAX_SLICE_SIZE_LOG+1 bits. Invalid config → cfg_error=1 next cycle, stay IDLE, nothing latched.
  - RUN: s_ready = !out_full || x_ready. On s_valid&&s_ready, the sample and the flags computed from the current counters load the output register; counters then advance.
  - RUN → DRAIN when the x_last_i sample is accepted on input. In RUN, s_ready is 0 once the last-image sample has been accepted.
  - DRAIN: s_ready=0; when the output register empties (x_valid&&x_ready), go to IDLE and drop busy the same edge.
- Counters: col (0..cols_m1), row (0..rows_m1), band (0..bands_m1), slice (0..slices_m1).
  - col wraps → row increments.
  - row wraps → band increments.
  - band wraps → slice increments.
- Flags:
  - last_r = col==cols_m1.
  - last_s = last_r && row==rows_m1.
  - last_b = last_s && band==bands_m1.
  - last_i = last_b && slice==slices_m1.
  - Flags are registered with the sample; they are never asserted without x_valid.
- Latency and throughput:
  - Latency s→x is exactly 1 cycle through a single output register.
  - Full throughput of 1 sample/cycle when x_ready is held high.
  - Output register holds x_data and flags stable while x_valid && !x_ready.
- Simultaneous input accept and output handshake in the same cycle replaces the register content; no bubble.
- start asserted while not IDLE is ignored and produces no cfg_error.
- All _m1 fields = 0: every sample carries all four flags.

Optional Feature:
- Macro LCPLC_SEQ_STALL_COUNT_EN.
- Defined:
  - Adds output stall_cycles [31:0]: counts cycles in RUN/DRAIN with x_valid && !x_ready.
  - Cleared on reset and on accepted start; saturates at 2^32-1.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Geometry check: cols_m1=3, rows_m1=1, bands_m1=1, slices_m1=1, quant_shift=2, threshold=0x100000, x_ready=1.
  - 32 samples out in order.
  - last_r at indices 3,7,11,...
  - last_s at 7,15,23,31.
  - last_b at 15,31.
  - last_i only at 31.
  - busy drops one cycle after output 31.
  - cfg outputs = 2 / 0x100000.
- Backpressure: x_ready toggled 1-of-3 cycles with the same config.
  - Identical data and flag sequence; no loss or duplication.
  - x_data and flags stable while stalled.
  - With macro: stall_cycles equals the counted stall cycles.
- Invalid config: cols_m1=31, rows_m1=15 (512 > 256).
  - cfg_error pulses one cycle; busy stays 0; s_ready stays 0; latched cfg unchanged.
- Degenerate geometry: all _m1=0, one sample 0xABCD.
  - x_data=0xABCD with all four flags set; return to IDLE.
- Mid-image reset and ignored start:
  - Assert rst after 10 samples: x_valid, s_ready, busy drop immediately.
  - New start after reset produces a clean flag sequence from index 0.
  - start pulsed during RUN is ignored.

Source files
------------

// File: rtl/lcplc_input_sequencer.sv
// Input sequencer for the LCPLC coder: reorders nothing, but tags each sample with
// row/slice/band/image last flags and holds the per-image coder config. Optional: LCPLC_SEQ_STALL_COUNT_EN.
module lcplc_input_sequencer #(
  parameter int unsigned DATA_WIDTH            = 16,
  parameter int unsigned MAX_SLICE_SIZE_LOG    = 8,
  parameter int unsigned BAND_WIDTH            = 10,
  parameter int unsigned SLICE_CNT_WIDTH       = 16,
  parameter int unsigned QUANTIZER_SHIFT_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [MAX_SLICE_SIZE_LOG-1:0]    cfg_cols_m1,
  input  logic [MAX_SLICE_SIZE_LOG-1:0]    cfg_rows_m1,
  input  logic [BAND_WIDTH-1:0]            cfg_bands_m1,
  input  logic [SLICE_CNT_WIDTH-1:0]       cfg_slices_m1,
  input  logic [QUANTIZER_SHIFT_WIDTH-1:0] cfg_quant_shift_in,
  input  logic [63:0]                      cfg_threshold_in,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [DATA_WIDTH-1:0]            s_data,
  output logic                             x_valid,
  input  logic                             x_ready,
  output logic [DATA_WIDTH-1:0]            x_data,
  output logic                             x_last_r,
  output logic                             x_last_s,
  output logic                             x_last_b,
  output logic                             x_last_i,
  output logic [QUANTIZER_SHIFT_WIDTH-1:0] cfg_quant_shift,
  output logic [63:0]                      cfg_threshold,
  output logic                             busy,
  output logic                             cfg_error
`ifdef LCPLC_SEQ_STALL_COUNT_EN
  ,
  output logic [31:0]                      stall_cycles
`endif
);

  localparam int unsigned PW = 2 * MAX_SLICE_SIZE_LOG + 1;
  localparam logic [PW-1:0] MAX_AREA = PW'(1) << MAX_SLICE_SIZE_LOG;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t                           state_q, state_d;
  logic [MAX_SLICE_SIZE_LOG-1:0]    cols_q, cols_d, rows_q, rows_d;
  logic [BAND_WIDTH-1:0]            bands_q, bands_d;
  logic [SLICE_CNT_WIDTH-1:0]       slices_q, slices_d;
  logic [QUANTIZER_SHIFT_WIDTH-1:0] qshift_q, qshift_d;
  logic [63:0]                      thr_q, thr_d;
  logic [MAX_SLICE_SIZE_LOG-1:0]    col_q, col_d, row_q, row_d;
  logic [BAND_WIDTH-1:0]            band_q, band_d;
  logic [SLICE_CNT_WIDTH-1:0]       slice_q, slice_d;
  logic                             full_q, full_d;
  logic [DATA_WIDTH-1:0]            data_q, data_d;
  logic [3:0]                       flags_q, flags_d;
  logic                             cfg_err_q, cfg_err_d;
  logic [31:0]                      stall_q, stall_d;

  logic [PW-1:0] cols_p1, rows_p1, area;
  logic          cfg_ok;
  logic          lr, ls, lb, li;
  logic          accept;

  assign cols_p1 = PW'(cfg_cols_m1) + PW'(1);
  assign rows_p1 = PW'(cfg_rows_m1) + PW'(1);
  assign area    = cols_p1 * rows_p1;
  assign cfg_ok  = (area <= MAX_AREA);

  assign lr = (col_q == cols_q);
  assign ls = lr && (row_q == rows_q);
  assign lb = ls && (band_q == bands_q);
  assign li = lb && (slice_q == slices_q);

  always_comb begin
    state_d   = state_q;
    cols_d    = cols_q;
    rows_d    = rows_q;
    bands_d   = bands_q;
    slices_d  = slices_q;
    qshift_d  = qshift_q;
    thr_d     = thr_q;
    col_d     = col_q;
    row_d     = row_q;
    band_d    = band_q;
    slice_d   = slice_q;
    full_d    = full_q;
    data_d    = data_q;
    flags_d   = flags_q;
    cfg_err_d = 1'b0;
    stall_d   = stall_q;
    s_ready   = 1'b0;
    accept    = 1'b0;

    if (state_q != ST_IDLE && full_q && !x_ready && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            cols_d   = cfg_cols_m1;
            rows_d   = cfg_rows_m1;
            bands_d  = cfg_bands_m1;
            slices_d = cfg_slices_m1;
            qshift_d = cfg_quant_shift_in;
            thr_d    = cfg_threshold_in;
            col_d    = '0;
            row_d    = '0;
            band_d   = '0;
            slice_d  = '0;
            stall_d  = '0;
            state_d  = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        s_ready = !full_q || x_ready;
        accept  = s_valid && s_ready;
        if (accept) begin
          full_d  = 1'b1;
          data_d  = s_data;
          flags_d = {lr, ls, lb, li};
          // Nested wrap: each counter only moves when every inner one wraps.
          if (lr) begin
            col_d = '0;
            if (ls) begin
              row_d = '0;
              if (lb) begin
                band_d  = '0;
                slice_d = li ? '0 : slice_q + 1'b1;
              end else begin
                band_d = band_q + 1'b1;
              end
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
          if (li) state_d = ST_DRAIN;
        end else if (x_ready) begin
          full_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (!full_q || x_ready) begin
          full_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cols_q    <= '0;
      rows_q    <= '0;
      bands_q   <= '0;
      slices_q  <= '0;
      qshift_q  <= '0;
      thr_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      band_q    <= '0;
      slice_q   <= '0;
      full_q    <= 1'b0;
      data_q    <= '0;
      flags_q   <= '0;
      cfg_err_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      cols_q    <= cols_d;
      rows_q    <= rows_d;
      bands_q   <= bands_d;
      slices_q  <= slices_d;
      qshift_q  <= qshift_d;
      thr_q     <= thr_d;
      col_q     <= col_d;
      row_q     <= row_d;
      band_q    <= band_d;
      slice_q   <= slice_d;
      full_q    <= full_d;
      data_q    <= data_d;
      flags_q   <= flags_d;
      cfg_err_q <= cfg_err_d;
      stall_q   <= stall_d;
    end
  end

  assign x_valid         = full_q;
  assign x_data          = data_q;
  assign x_last_r        = flags_q[3] && full_q;
  assign x_last_s        = flags_q[2] && full_q;
  assign x_last_b        = flags_q[1] && full_q;
  assign x_last_i        = flags_q[0] && full_q;
  assign cfg_quant_shift = qshift_q;
  assign cfg_threshold   = thr_q;
  assign busy            = (state_q != ST_IDLE);
  assign cfg_error       = cfg_err_q;

`ifdef LCPLC_SEQ_STALL_COUNT_EN
  assign stall_cycles = stall_q;
`else
  logic unused_stall;
  assign unused_stall = ^stall_q;
`endif

endmodule
